planificador_nonce: RTL and testbench

Scheduler that shares a bank of `CORES` hash cores (`sistema_x`-class datapaths) across one nonce search. It latches a 12-byte header and an 8-bit target on `start`, then hands out consecutive nonce windows of 2^`WIN_BITS` nonces to idle cores. It collects hits, aborts all cores on the first hit, and reports one winning nonce with a `finished` pulse. It sits between the top-level system interface and the core bank.

---
 rtl/planificador_nonce_if.sv | 30 +++
 rtl/planificador_nonce.sv | 231 +++++++++++++++++++++++
 tb/tb_planificador_nonce.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/planificador_nonce_if.sv
// planificador_nonce_if: bundle between the nonce scheduler and its bank of
// hash cores.
//   master (scheduler side): drives core_go, core_base, core_data,
//                            core_target, core_abort; receives core_done,
//                            core_hit, core_nonce.
//   slave  (core bank side): the mirror image.
// core_nonce packs core i's nonce into bits [32i+31:32i].
interface planificador_nonce_if #(
  parameter int BYTE  = 8,
  parameter int CORES = 2
);
  logic [CORES-1:0]    core_go;
  logic [31:0]         core_base;
  logic [12*BYTE-1:0]  core_data;
  logic [7:0]          core_target;
  logic                core_abort;
  logic [CORES-1:0]    core_done;
  logic [CORES-1:0]    core_hit;
  logic [32*CORES-1:0] core_nonce;

  modport master (
    output core_go, core_base, core_data, core_target, core_abort,
    input  core_done, core_hit, core_nonce
  );

  modport slave (
    input  core_go, core_base, core_data, core_target, core_abort,
    output core_done, core_hit, core_nonce
  );
endinterface

// File: rtl/planificador_nonce.sv
// planificador_nonce: shares CORES hash cores across one nonce search.
// On an accepted start it latches the 12-byte header and the 8-bit target,
// then hands consecutive windows of 2^WIN_BITS nonces to idle cores
// (lowest index first, one per cycle). The first hit aborts every core and
// the winning nonce is reported with a one-cycle finished pulse.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           search request (honoured only when idle)
//   data_in/target  header and difficulty target, latched on start
//   max_windows     window budget (only with PLANIFICADOR_LIMITE_EN)
//   busy            high whenever the scheduler is not idle
//   finished        one-cycle end-of-search pulse
//   found/nonce_out result, held until the next accepted start
//   core_bus        core bank bundle (planificador_nonce_if.master)
//
// Optional feature: define PLANIFICADOR_LIMITE_EN to add the max_windows
// input, which ends the search once that many windows have been dispatched.
module planificador_nonce #(
  parameter int BYTE     = 8,
  parameter int CORES    = 2,
  parameter int WIN_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [12*BYTE-1:0]  data_in,
  input  logic [7:0]          target,
`ifdef PLANIFICADOR_LIMITE_EN
  input  logic [15:0]         max_windows,
`endif
  output logic                busy,
  output logic                finished,
  output logic                found,
  output logic [31:0]         nonce_out,
  planificador_nonce_if.master core_bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_ABORT  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  // One window worth of nonces; bit 32 of the sum is the wrap carry.
  localparam logic [32:0] WIN_STEP = 33'd1 << WIN_BITS;

  state_t              state_q, state_d;
  logic [31:0]         next_base_q, next_base_d;
  logic [CORES-1:0]    pend_q, pend_d;
  logic                exhausted_q, exhausted_d;
  logic                found_q, found_d;
  logic [31:0]         nonce_q, nonce_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic [CORES-1:0]    go_q, go_d;
  logic [31:0]         base_q, base_d;
  logic [12*BYTE-1:0]  data_q, data_d;
  logic [7:0]          target_q, target_d;
  logic                abort_q, abort_d;
`ifdef PLANIFICADOR_LIMITE_EN
  logic [15:0]         win_cnt_q, win_cnt_d;
  logic [15:0]         max_q, max_d;
`endif

  logic [CORES-1:0]    done_v;
  logic [CORES-1:0]    hit_v;
  logic [31:0]         hit_nonce;
  logic [CORES-1:0]    idle_oh;
  logic [32:0]         step_sum;

  // Priority pick: lowest-index hit nonce and lowest-index idle core.
  // Completions from cores that hold no window are masked out here.
  always_comb begin
    done_v    = core_bus.core_done & pend_q;
    hit_v     = done_v & core_bus.core_hit;
    hit_nonce = 32'h0000_0000;
    idle_oh   = {CORES{1'b0}};
    // Walk from the top down so the lowest index is written last and wins.
    for (int i = CORES - 1; i >= 0; i--) begin
      hit_nonce = hit_v[i] ? core_bus.core_nonce[i*32 +: 32] : hit_nonce;
      idle_oh   = pend_q[i] ? idle_oh : (CORES'(1'b1) << i);
    end
    step_sum = {1'b0, next_base_q} + WIN_STEP;
  end

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    next_base_d = next_base_q;
    pend_d      = pend_q;
    exhausted_d = exhausted_q;
    found_d     = found_q;
    nonce_d     = nonce_q;
    go_d        = {CORES{1'b0}};
    base_d      = base_q;
    data_d      = data_q;
    target_d    = target_q;
    abort_d     = 1'b0;
    finished_d  = 1'b0;
`ifdef PLANIFICADOR_LIMITE_EN
    win_cnt_d   = win_cnt_q;
    max_d       = max_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d      = data_in;
          target_d    = target;
          next_base_d = 32'h0000_0000;
          pend_d      = {CORES{1'b0}};
          found_d     = 1'b0;
          nonce_d     = 32'h0000_0000;
`ifdef PLANIFICADOR_LIMITE_EN
          win_cnt_d   = 16'd0;
          max_d       = max_windows;
          // A zero budget is exhausted before anything is handed out.
          exhausted_d = (max_windows == 16'd0);
`else
          exhausted_d = 1'b0;
`endif
          state_d     = S_RUN;
        end else begin
          state_d     = S_IDLE;
        end
      end

      S_RUN: begin
        if (hit_v != {CORES{1'b0}}) begin
          // A hit suppresses dispatch for this cycle.
          found_d = 1'b1;
          nonce_d = hit_nonce;
          pend_d  = pend_q & ~done_v;
          state_d = S_ABORT;
        end else begin
          // Idle cores come from pend_q, so a core finishing now is only
          // eligible next cycle.
          pend_d = pend_q & ~done_v;
          if ((idle_oh != {CORES{1'b0}}) && !exhausted_q) begin
            go_d        = idle_oh;
            base_d      = next_base_q;
            pend_d      = (pend_q & ~done_v) | idle_oh;
            next_base_d = step_sum[31:0];
`ifdef PLANIFICADOR_LIMITE_EN
            win_cnt_d   = win_cnt_q + 16'd1;
            exhausted_d = step_sum[32] | ((win_cnt_q + 16'd1) == max_q);
`else
            exhausted_d = step_sum[32];
`endif
          end else if (exhausted_q && (pend_q == {CORES{1'b0}})) begin
            state_d = S_REPORT;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_ABORT: begin
        abort_d = 1'b1;
        pend_d  = {CORES{1'b0}};
        state_d = S_REPORT;
      end

      S_REPORT: begin
        finished_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy follows the state the FSM is entering, so it tracks state_q.
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      next_base_q <= 32'h0000_0000;
      pend_q      <= {CORES{1'b0}};
      exhausted_q <= 1'b0;
      found_q     <= 1'b0;
      nonce_q     <= 32'h0000_0000;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      go_q        <= {CORES{1'b0}};
      base_q      <= 32'h0000_0000;
      data_q      <= {(12*BYTE){1'b0}};
      target_q    <= 8'h00;
      abort_q     <= 1'b0;
`ifdef PLANIFICADOR_LIMITE_EN
      win_cnt_q   <= 16'd0;
      max_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      next_base_q <= next_base_d;
      pend_q      <= pend_d;
      exhausted_q <= exhausted_d;
      found_q     <= found_d;
      nonce_q     <= nonce_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      go_q        <= go_d;
      base_q      <= base_d;
      data_q      <= data_d;
      target_q    <= target_d;
      abort_q     <= abort_d;
`ifdef PLANIFICADOR_LIMITE_EN
      win_cnt_q   <= win_cnt_d;
      max_q       <= max_d;
`endif
    end
  end

  assign busy                 = busy_q;
  assign finished             = finished_q;
  assign found                = found_q;
  assign nonce_out            = nonce_q;
  assign core_bus.core_go     = go_q;
  assign core_bus.core_base   = base_q;
  assign core_bus.core_data   = data_q;
  assign core_bus.core_target = target_q;
  assign core_bus.core_abort  = abort_q;

endmodule

// File: tb/tb_planificador_nonce.sv
// Bench for planificador_nonce (CORES=2, WIN_BITS=8). Expected dispatches
// are queued when a search is started and popped as core_go pulses appear.
module tb_planificador_nonce;
  localparam int BYTE     = 8;
  localparam int CORES    = 2;
  localparam int WIN_BITS = 8;
  localparam logic [95:0] HDR_A = 96'h0123_4567_89AB_CDEF_0011_2233;
  localparam logic [95:0] HDR_B = 96'hFEDC_BA98_7654_3210_A5A5_5A5A;

  typedef struct packed {
    logic [CORES-1:0] go;
    logic [31:0]      base;
  } disp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [95:0] data_in;
  logic [7:0]  target;
  logic        busy;
  logic        finished;
  logic        found;
  logic [31:0] nonce_out;
`ifdef PLANIFICADOR_LIMITE_EN
  logic [15:0] max_windows;
`endif

  planificador_nonce_if #(.BYTE(BYTE), .CORES(CORES)) cif ();

  planificador_nonce #(.BYTE(BYTE), .CORES(CORES), .WIN_BITS(WIN_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .target     (target),
`ifdef PLANIFICADOR_LIMITE_EN
    .max_windows(max_windows),
`endif
    .busy       (busy),
    .finished   (finished),
    .found      (found),
    .nonce_out  (nonce_out),
    .core_bus   (cif)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  disp_t exp_q[$];
  disp_t obs_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout want completion");
    $fatal(1);
  end

  // Records up to n core_go pulses into obs_q within budget cycles.
  task automatic collect_go(input int n, input int budget, output bit timed_out);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (cif.core_go != '0) begin
        obs_q.push_back('{cif.core_go, cif.core_base});
        got++;
      end
    end
    timed_out = (got < n);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; data_in = '0; target = 8'h00;
    cif.core_done = '0; cif.core_hit = '0; cif.core_nonce = '0;
`ifdef PLANIFICADOR_LIMITE_EN
    max_windows = 16'd0;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, finished, found, cif.core_abort, cif.core_go} !== 6'b0) begin
      $display("FAIL reset_flags got %b want 000000", {busy, finished, found, cif.core_abort, cif.core_go});
      miscompares++;
    end
    vectors++;
    if (nonce_out !== 32'h0 || cif.core_base !== 32'h0) begin
      $display("FAIL reset_nonce_base got %h/%h want 0/0", nonce_out, cif.core_base);
      miscompares++;
    end
    vectors++;
    if (cif.core_data !== 96'h0 || cif.core_target !== 8'h00) begin
      $display("FAIL reset_latches got %h/%h want 0/0", cif.core_data, cif.core_target);
      miscompares++;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || cif.core_go !== 2'b00) begin
      $display("FAIL reset_release_idle got busy=%b go=%b want 0/00", busy, cif.core_go);
      miscompares++;
    end
  endtask

  task automatic test_startup();
    disp_t e;
    int    extra;
    data_in = HDR_A; target = 8'h10; start = 1'b1;
    exp_q.push_back('{2'b01, 32'h0000_0000});
    exp_q.push_back('{2'b10, 32'h0000_0100});
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || cif.core_go !== 2'b00) begin
      $display("FAIL startup_first_cycle got busy=%b go=%b want 1/00", busy, cif.core_go);
      miscompares++;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (cif.core_go !== e.go || cif.core_base !== e.base) begin
        $display("FAIL startup_dispatch%0d got %b/%h want %b/%h", k, cif.core_go, cif.core_base, e.go, e.base);
        miscompares++;
      end
    end
    vectors++;
    if (cif.core_data !== HDR_A || cif.core_target !== 8'h10) begin
      $display("FAIL startup_latch got %h/%h want %h/10", cif.core_data, cif.core_target, HDR_A);
      miscompares++;
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (cif.core_go != 2'b00) extra++;
    end
    vectors++;
    if (extra !== 0 || busy !== 1'b1) begin
      $display("FAIL startup_quiet got extra=%0d busy=%b want 0/1", extra, busy);
      miscompares++;
    end
  endtask

  task automatic test_redispatch();
    disp_t e;
    int    aborts;
    cif.core_done = 2'b01; cif.core_hit = 2'b00;
    exp_q.push_back('{2'b01, 32'h0000_0200});
    @(negedge clk);
    vectors++;
    if (cif.core_go !== 2'b00) begin
      $display("FAIL redispatch_idle_cycle got %b want 00", cif.core_go);
      miscompares++;
    end
    // Core 0 holds no window in this cycle, so this hit must be dropped.
    cif.core_done = 2'b01; cif.core_hit = 2'b01; cif.core_nonce = {32'h0, 32'hDEAD_BEEF};
    @(negedge clk);
    cif.core_done = 2'b00; cif.core_hit = 2'b00;
    e = exp_q.pop_front();
    vectors++;
    if (cif.core_go !== e.go || cif.core_base !== e.base) begin
      $display("FAIL redispatch_go got %b/%h want %b/%h", cif.core_go, cif.core_base, e.go, e.base);
      miscompares++;
    end
    aborts = 0;
    repeat (4) begin
      @(negedge clk);
      if (cif.core_abort || finished) aborts++;
    end
    vectors++;
    if (aborts !== 0 || found !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL ignored_done got aborts=%0d found=%b busy=%b want 0/0/1", aborts, found, busy);
      miscompares++;
    end
  endtask

  task automatic test_ignored_start();
    int events;
    data_in = HDR_B; target = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    events = 0;
    repeat (3) begin
      @(negedge clk);
      if (cif.core_go != 2'b00 || finished || cif.core_abort) events++;
    end
    vectors++;
    if (cif.core_data !== HDR_A || cif.core_target !== 8'h10) begin
      $display("FAIL ignored_start_latch got %h/%h want %h/10", cif.core_data, cif.core_target, HDR_A);
      miscompares++;
    end
    vectors++;
    if (events !== 0 || busy !== 1'b1) begin
      $display("FAIL ignored_start_state got events=%0d busy=%b want 0/1", events, busy);
      miscompares++;
    end
  endtask

  task automatic test_simultaneous_hits();
    cif.core_done = 2'b11; cif.core_hit = 2'b11;
    cif.core_nonce = {32'h0000_0155, 32'h0000_0042};
    @(negedge clk);
    cif.core_done = 2'b00; cif.core_hit = 2'b00;
    vectors++;
    if (cif.core_abort !== 1'b0 || cif.core_go !== 2'b00) begin
      $display("FAIL hit_cycle got abort=%b go=%b want 0/00", cif.core_abort, cif.core_go);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (cif.core_abort !== 1'b1 || finished !== 1'b0 || found !== 1'b1 || nonce_out !== 32'h42) begin
      $display("FAIL hit_abort got abort=%b fin=%b found=%b nonce=%h want 1/0/1/00000042",
               cif.core_abort, finished, found, nonce_out);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (finished !== 1'b1 || cif.core_abort !== 1'b0 || found !== 1'b1 || nonce_out !== 32'h42) begin
      $display("FAIL hit_finished got fin=%b abort=%b found=%b nonce=%h want 1/0/1/00000042",
               finished, cif.core_abort, found, nonce_out);
      miscompares++;
    end
  endtask

  // Starts again in the very cycle finished is visible.
  task automatic test_back_to_back();
    disp_t e;
    data_in = HDR_B; target = 8'h22; start = 1'b1;
    exp_q.push_back('{2'b01, 32'h0000_0000});
    exp_q.push_back('{2'b10, 32'h0000_0100});
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (found !== 1'b0 || nonce_out !== 32'h0 || busy !== 1'b1 || finished !== 1'b0) begin
      $display("FAIL b2b_restart got found=%b nonce=%h busy=%b fin=%b want 0/0/1/0", found, nonce_out, busy, finished);
      miscompares++;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (cif.core_go !== e.go || cif.core_base !== e.base) begin
        $display("FAIL b2b_dispatch%0d got %b/%h want %b/%h", k, cif.core_go, cif.core_base, e.go, e.base);
        miscompares++;
      end
    end
    vectors++;
    if (cif.core_data !== HDR_B || cif.core_target !== 8'h22) begin
      $display("FAIL b2b_latch got %h/%h want %h/22", cif.core_data, cif.core_target, HDR_B);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    disp_t e, o;
    bit    to;
    int    fins;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, finished, found, cif.core_abort, cif.core_go, nonce_out, cif.core_base, cif.core_target} !== '0
        || cif.core_data !== 96'h0) begin
      $display("FAIL reset_mid_outputs got busy=%b go=%b base=%h data=%h want all 0",
               busy, cif.core_go, cif.core_base, cif.core_data);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b1;
    fins = 0;
    repeat (5) begin
      @(negedge clk);
      if (finished || busy) fins++;
    end
    vectors++;
    if (fins !== 0) begin
      $display("FAIL reset_mid_no_finish got %0d want 0", fins);
      miscompares++;
    end
    data_in = HDR_A; target = 8'h10; start = 1'b1;
    exp_q.push_back('{2'b01, 32'h0000_0000});
    @(negedge clk);
    start = 1'b0;
    collect_go(1, 5, to);
    vectors++;
    if (to) begin
      $display("FAIL reset_mid_restart got timeout want core_go");
      miscompares++;
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o !== e) begin
        $display("FAIL reset_mid_restart got %b/%h want %b/%h", o.go, o.base, e.go, e.base);
        miscompares++;
      end
    end
  endtask

`ifdef PLANIFICADOR_LIMITE_EN
  task automatic test_limit();
    disp_t e;
    int    gos, aborts, fin_at;
    bit    fin_found, fin_seen;
    logic [31:0] fin_nonce;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; cif.core_done = 2'b00; cif.core_hit = 2'b00;
    @(negedge clk);
    max_windows = 16'd3; start = 1'b1;
    exp_q.push_back('{2'b01, 32'h0000_0000});
    exp_q.push_back('{2'b10, 32'h0000_0100});
    exp_q.push_back('{2'b01, 32'h0000_0200});
    @(negedge clk);
    start = 1'b0;
    gos = 0; aborts = 0; fin_seen = 1'b0; fin_found = 1'b1; fin_nonce = 32'hFFFF_FFFF;
    for (int c = 0; c < 40 && !fin_seen; c++) begin
      @(negedge clk);
      if (cif.core_go != 2'b00) begin
        gos++;
        vectors++;
        if (exp_q.size() == 0) begin
          $display("FAIL limit_extra_go got %b/%h want none", cif.core_go, cif.core_base);
          miscompares++;
        end else begin
          e = exp_q.pop_front();
          if (cif.core_go !== e.go || cif.core_base !== e.base) begin
            $display("FAIL limit_dispatch got %b/%h want %b/%h", cif.core_go, cif.core_base, e.go, e.base);
            miscompares++;
          end
        end
      end
      cif.core_done = cif.core_go;
      if (cif.core_abort) aborts++;
      if (finished) begin
        fin_seen = 1'b1; fin_found = found; fin_nonce = nonce_out;
      end
    end
    cif.core_done = 2'b00;
    vectors++;
    if (!fin_seen || gos !== 3 || aborts !== 0 || fin_found !== 1'b0 || fin_nonce !== 32'h0) begin
      $display("FAIL limit_end got fin=%b gos=%0d aborts=%0d found=%b nonce=%h want 1/3/0/0/0",
               fin_seen, gos, aborts, fin_found, fin_nonce);
      miscompares++;
    end
    // Zero budget: finished two cycles after start, no dispatch at all.
    max_windows = 16'd0; start = 1'b1;
    fin_at = 0; gos = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (cif.core_go != 2'b00) gos++;
      if (finished && fin_at == 0) fin_at = c;
    end
    vectors++;
    if (fin_at !== 3 || gos !== 0 || found !== 1'b0) begin
      $display("FAIL limit_zero got fin_at=%0d gos=%0d found=%b want 3/0/0", fin_at, gos, found);
      miscompares++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_redispatch();
    test_ignored_start();
    test_simultaneous_hits();
    test_back_to_back();
    test_reset_mid();
`ifdef PLANIFICADOR_LIMITE_EN
    test_limit();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
